// File: rtl/sha256_compress_core.sv
// sha256_compress_core: iterative SHA-256 compression, one round per clock.
// Presents the final working variables a..h; the Hn feed-forward add lives downstream.
module sha256_compress_core #(
   parameter int NROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] h_in,
   input  logic [31:0]  w_in,
   input  logic         w_valid,
   output logic         w_ready,
   output logic         busy,
   output logic         done,
   output logic [5:0]   round,
   output logic [255:0] state_out,
   output logic [31:0]  b_out
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   state_t        state_q;
   logic [255:0]  v_q, v_d;
   logic [5:0]    round_q;
   logic [31:0]   a, b, c, d, e, f, g, h, t1, t2;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] k_rom(input logic [5:0] t);
      case (t)
         6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;  6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
         6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;  6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
         6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;  6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
         6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;  6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
         6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;  6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
         6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;  6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
         6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;  6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
         6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;  6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
         6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;  6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
         6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;  6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
         6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;  6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
         6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;  6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
         6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;  6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
         6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;  6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
         6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;  6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
         6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;  6'd62: return 32'hbef9a3f7;  default: return 32'hc67178f2;
      endcase
   endfunction

   always_comb begin
      {a, b, c, d, e, f, g, h} = v_q;
      t1  = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_rom(round_q) + w_in;
      t2  = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      v_d = {t1 + t2, a, b, c, d + t1, e, f, g};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         v_q     <= IV;
         round_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               v_q     <= h_in;
               round_q <= '0;
               state_q <= ROUND;
            end
            ROUND: if (w_valid) begin
               v_q     <= v_d;
               round_q <= (round_q == 6'(NROUNDS - 1)) ? 6'd0 : round_q + 6'd1;
               state_q <= (round_q == 6'(NROUNDS - 1)) ? DONE : ROUND;
            end
            DONE: begin
               if (start) v_q <= h_in;
               round_q <= '0;
               state_q <= start ? ROUND : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = state_q == ROUND;
   assign done      = state_q == DONE;
   assign w_ready   = busy;
   assign round     = round_q;
   assign state_out = v_q;
   assign b_out     = v_q[223:192];
endmodule

// File: tb/tb_sha256_compress_core.sv
// tb_sha256_compress_core: directed SHA-256 compression checks against a reference model.
// Expected a..h are queued at block start and popped when the core signals done.
module tb_sha256_compress_core;
   typedef logic [31:0] sched_t [64];
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                          32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         rst, start, w_valid;
   logic [255:0] h_in;
   logic [31:0]  w_in;
   logic         w_ready, busy, done;
   logic [5:0]   round;
   logic [255:0] state_out;
   logic [31:0]  b_out;

   int           checks = 0, errors = 0;
   int           cyc, stalls;
   logic [255:0] exp_q [$];
   logic [255:0] exp_v, last_v, dig;
   logic [511:0] blk;
   sched_t       w_abc, w_zero;

   sha256_compress_core dut (
      .clk(clk), .rst(rst), .start(start), .h_in(h_in), .w_in(w_in), .w_valid(w_valid),
      .w_ready(w_ready), .busy(busy), .done(done), .round(round), .state_out(state_out), .b_out(b_out));

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic sched_t expand(input logic [511:0] m);
      sched_t w;
      for (int t = 0; t < 64; t++)
         w[t] = (t < 16) ? m[511 - 32*t -: 32] :
                (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      return w;
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hv, input sched_t w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = hv;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         {a, b, c, d, e, f, g, h} = {t1 + t2, a, b, c, d + t1, e, f, g};
      end
      return {a, b, c, d, e, f, g, h};
   endfunction

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Start must already be driven; returns on the negedge where done is seen.
   task automatic feed(input sched_t w, input int stall_mod, input int ign_at, output int n, output int ns);
      int idx;
      idx = 0; n = 0; ns = 0;
      forever begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (done === 1'b1) break;
         if (n > 300) begin
            checks++; errors++;
            $error("FAIL timeout: observed no done after %0d cycles expected done", n);
            break;
         end
         chk("busy_round", busy, 1);
         chk("round_idx", round, idx[5:0]);
         w_valid = (stall_mod == 0) || (n % stall_mod != 0);
         if (!w_valid) ns++;
         w_in = (idx < 64) ? w[idx] : 32'h0;
         if (idx == ign_at) start = 1'b1;
         if (w_valid) idx++;
      end
      w_valid = 1'b0;
   endtask

   task automatic finish_block(input int n, input int ns);
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $error("FAIL scoreboard: observed empty queue expected entry");
         return;
      end
      exp_v = exp_q.pop_front();
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("latency", n, 65 + ns);
      chk("state_out", state_out, exp_v);
      chk("b_out", b_out, exp_v[223:192]);
      last_v = exp_v;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; w_valid = 1'b0; h_in = '0; w_in = '0;
      blk = '0; blk[511:480] = 32'h61626380; blk[31:0] = 32'h00000018;
      w_abc = expand(blk);
      w_zero = expand('0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_round", round, 0);
      chk("rst_state", state_out, IV);
      chk("rst_b_out", b_out, 32'hbb67ae85);

      // mid-block asynchronous reset at round 30
      h_in = ~IV; start = 1'b1;
      for (int i = 0; i <= 30; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i < 30) begin w_valid = 1'b1; w_in = w_abc[i]; end
      end
      chk("mid_round30", round, 30);
      w_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_round", round, 0);
      chk("mid_rst_b_out", b_out, 32'hbb67ae85);
      chk("mid_rst_state", state_out, IV);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_w_ready", w_ready, 0);
         chk("post_rst_busy", busy, 0);
      end

      // "abc" block, no stalls
      h_in = IV; start = 1'b1;
      exp_q.push_back(compress(IV, w_abc));
      feed(w_abc, 0, -1, cyc, stalls);
      finish_block(cyc, stalls);
      chk("abc_a", state_out[255:224], 32'h506e3058);
      chk("abc_b_out", b_out, 32'hd39a2165);
      for (int k = 0; k < 8; k++) dig[255 - 32*k -: 32] = state_out[255 - 32*k -: 32] + IV[255 - 32*k -: 32];
      chk("abc_digest", dig, ABC_DIGEST);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);

      // same block with w_valid low every third cycle, then back-to-back zero block
      h_in = IV; start = 1'b1;
      exp_q.push_back(compress(IV, w_abc));
      feed(w_abc, 3, -1, cyc, stalls);
      finish_block(cyc, stalls);
      chk("stall_count", stalls > 0, 1);
      h_in = ABC_DIGEST; start = 1'b1;
      exp_q.push_back(compress(ABC_DIGEST, w_zero));
      feed(w_zero, 0, -1, cyc, stalls);
      finish_block(cyc, stalls);
      @(negedge clk);
      chk("b2b_done_drop", done, 0);

      // start pulsed mid-block must be ignored
      h_in = IV; start = 1'b1;
      exp_q.push_back(compress(IV, w_abc));
      feed(w_abc, 0, 10, cyc, stalls);
      finish_block(cyc, stalls);

      // idle hold
      h_in = ~IV;
      repeat (20) begin
         @(negedge clk);
         chk("hold_busy", busy, 0);
         chk("hold_w_ready", w_ready, 0);
         chk("hold_state", state_out, last_v);
      end
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
